// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: FSM encoding, default width, bit-cell helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package arith_pkg;

    // Default operand width for the arithmetic lab blocks
    localparam int ARITH_WIDTH = 8;

    // Sequencer state encoding shared by the serial arithmetic blocks
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Two-of-three majority: the carry function of a full adder
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell used as the datapath of the bit-serial adder.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module full_adder
    import arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = maj3(a, b, cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit unsigned adder: one full-adder cell, LSB first, registered carry.
// Latency: start accepted at edge k, done high in the cycle after edge k+WIDTH.
// Backpressure: start is only sampled in IDLE; requests during SHIFT/DONE are dropped.
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    // Only the upper WIDTH-1 result bits need storage; the MSB comes straight
    // from the adder cell on the final bit edge.
    logic [WIDTH-1:1] acc;
    logic [WIDTH-1:1] acc_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             bit_s;
    logic             bit_c;

    full_adder u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .s    (bit_s),
        .cout (bit_c)
    );

    // Partial accumulator after shifting the current sum bit in at the MSB
    always_comb begin
        acc_nxt          = acc >> 1;
        acc_nxt[WIDTH-1] = bit_s;
    end

    // Sequencer, operand shifters and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        acc   <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    acc   <= acc_nxt;
                    carry <= bit_c;
                    cnt   <= cnt + CNT_W'(1);
                    // Final bit: publish the whole result at once so the
                    // partial accumulator never reaches the outputs.
                    if (cnt == LAST_BIT) begin
                        sum   <= {bit_s, acc};
                        cout  <= bit_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
